regs_writeback: RTL and testbench

REGS_WRITEBACK -- requirements
Module: regs_writeback

---
 rtl/regs_pkg.sv | 35 +++
 rtl/wb_chan_fifo.sv | 67 ++++++
 rtl/regs_writeback.sv | 161 ++++++++++++++++
 tb/tb_regs_writeback.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared encodings and widths for the register-file writeback path.
package regs_pkg;

    localparam int unsigned THREAD_W = 5;
    localparam int unsigned CHAN_W   = 4;
    localparam int unsigned PTR_W    = 12;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PC_W     = 12;
    localparam int unsigned PSEL_W   = 2;
    localparam int unsigned DST_W    = 2;

    // Pipeline destination encodings
    localparam logic [DST_W-1:0] DST_NONE = 2'd0;
    localparam logic [DST_W-1:0] DST_A    = 2'd1;
    localparam logic [DST_W-1:0] DST_B    = 2'd2;
    localparam logic [DST_W-1:0] DST_PTR  = 2'd3;

    // Channel request kinds
    localparam logic CKIND_CSB     = 1'b0;
    localparam logic CKIND_MEMPAGE = 1'b1;

    // One queued channel request
    typedef struct packed {
        logic              ckind;
        logic [CHAN_W-1:0] chanid;
        logic [DATA_W-1:0] data;
    } chan_req_t;

    // A pipeline write to A, B or a pointer occupies d8 and/or wchanid,
    // which the channel path also needs; a PC-only write does not.
    function automatic logic uses_chan_bus(input logic pv, input logic [DST_W-1:0] pdst);
        return pv && (pdst != DST_NONE);
    endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Channel request queue: power-of-two depth, registered full/empty flags.
module wb_chan_fifo
    import regs_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  chan_req_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output logic      full_nxt_c,
    output chan_req_t head
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              do_push;
    logic              do_pop;
    chan_req_t         mem [DEPTH];

    // A push into a full queue is only legal alongside a pop
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this edge
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        full_nxt_c = (count_nxt == CNT_W'(DEPTH));
    end

    // Pointers, count and flags; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            full  <= full_nxt_c;
            empty <= (count_nxt == '0);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regs_writeback.sv
// Register-file writeback: merges pipeline writes with queued channel
// status/mempage updates, pipeline first, with a starvation stall.
module regs_writeback
    import regs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    // pipeline side
    input  logic                pv,
    input  logic [THREAD_W-1:0] pthreadid,
    input  logic [CHAN_W-1:0]   pchanid,
    input  logic [DST_W-1:0]    pdst,
    input  logic [PSEL_W-1:0]   ppsel,
    input  logic [DATA_W-1:0]   pd8,
    input  logic [PTR_W-1:0]    pd12,
    input  logic                ppcen,
    input  logic [PC_W-1:0]     pdpc,
    output logic                pstall,
    // channel side
    input  logic                cvalid,
    output logic                cready,
    input  logic [CHAN_W-1:0]   cchanid,
    input  logic                ckind,
    input  logic [DATA_W-1:0]   cdata,
    // register-file write port
    output logic [THREAD_W-1:0] wthreadid,
    output logic [CHAN_W-1:0]   wchanid,
    output logic [DATA_W-1:0]   d8,
    output logic                wea,
    output logic                web,
    output logic [PTR_W-1:0]    d12,
    output logic [PSEL_W-1:0]   pselw,
    output logic                wep,
    output logic [PC_W-1:0]     dpc,
    output logic                wepc,
    output logic                wecsb,
    output logic                wemempage
);

    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic            blocked_c;
    logic            push_c;
    logic            pop_c;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_full_nxt_c;
    chan_req_t       push_req_c;
    chan_req_t       head_c;
    logic [SCNT_W-1:0] starve_cnt;

    assign blocked_c  = uses_chan_bus(pv, pdst);
    assign push_c     = cvalid && cready;
    assign pop_c      = !fifo_empty && !blocked_c;
    assign push_req_c = '{ckind: ckind, chanid: cchanid, data: cdata};

    wb_chan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (push_req_c),
        .pop        (pop_c),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .full_nxt_c (fifo_full_nxt_c),
        .head       (head_c)
    );

    // cready tracks not-full after each edge; low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cready <= 1'b0;
        end else begin
            cready <= !fifo_full_nxt_c;
        end
    end

    // Starvation counter: full and blocked cycles, cleared by any pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pstall     <= 1'b0;
        end else begin
            pstall <= 1'b0;
            if (pop_c) begin
                starve_cnt <= '0;
            end else if (fifo_full && blocked_c) begin
                if (starve_cnt == SCNT_W'(STARVE_LIMIT - 1)) begin
                    starve_cnt <= '0;
                    pstall     <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + SCNT_W'(1);
                end
            end
        end
    end

    // Write port: enables pulse for one cycle, data/ids hold when unused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wthreadid <= '0;
            wchanid   <= '0;
            d8        <= '0;
            d12       <= '0;
            pselw     <= '0;
            dpc       <= '0;
            wea       <= 1'b0;
            web       <= 1'b0;
            wep       <= 1'b0;
            wepc      <= 1'b0;
            wecsb     <= 1'b0;
            wemempage <= 1'b0;
        end else begin
            wea       <= 1'b0;
            web       <= 1'b0;
            wep       <= 1'b0;
            wepc      <= 1'b0;
            wecsb     <= 1'b0;
            wemempage <= 1'b0;
            if (pv) begin
                case (pdst)
                    DST_A: begin
                        wea       <= 1'b1;
                        d8        <= pd8;
                        wthreadid <= pthreadid;
                    end
                    DST_B: begin
                        web       <= 1'b1;
                        d8        <= pd8;
                        wthreadid <= pthreadid;
                    end
                    DST_PTR: begin
                        wep       <= 1'b1;
                        pselw     <= ppsel;
                        d12       <= pd12;
                        wthreadid <= pthreadid;
                        wchanid   <= pchanid;
                    end
                    default: ;
                endcase
                if (ppcen) begin
                    wepc <= 1'b1;
                    dpc  <= pdpc;
                end
            end
            // pop_c already excludes any cycle using d8 or wchanid
            if (pop_c) begin
                wecsb     <= (head_c.ckind == CKIND_CSB);
                wemempage <= (head_c.ckind == CKIND_MEMPAGE);
                d8        <= head_c.data;
                wchanid   <= head_c.chanid;
            end
        end
    end

endmodule

// File: tb/tb_regs_writeback.sv
// Self-checking bench for regs_writeback against a queue-level model.
module tb_regs_writeback;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv = 1'b0;
    logic [4:0]  pthreadid = '0;
    logic [3:0]  pchanid = '0;
    logic [1:0]  pdst = '0;
    logic [1:0]  ppsel = '0;
    logic [7:0]  pd8 = '0;
    logic [11:0] pd12 = '0;
    logic        ppcen = 1'b0;
    logic [11:0] pdpc = '0;
    logic        pstall;
    logic        cvalid = 1'b0;
    logic        cready;
    logic [3:0]  cchanid = '0;
    logic        ckind = 1'b0;
    logic [7:0]  cdata = '0;
    logic [4:0]  wthreadid;
    logic [3:0]  wchanid;
    logic [7:0]  d8;
    logic        wea, web, wep, wepc, wecsb, wemempage;
    logic [11:0] d12;
    logic [1:0]  pselw;
    logic [11:0] dpc;

    regs_writeback #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pv(pv), .pthreadid(pthreadid), .pchanid(pchanid), .pdst(pdst),
        .ppsel(ppsel), .pd8(pd8), .pd12(pd12), .ppcen(ppcen), .pdpc(pdpc),
        .pstall(pstall),
        .cvalid(cvalid), .cready(cready), .cchanid(cchanid), .ckind(ckind),
        .cdata(cdata),
        .wthreadid(wthreadid), .wchanid(wchanid), .d8(d8), .wea(wea),
        .web(web), .d12(d12), .pselw(pselw), .wep(wep), .dpc(dpc),
        .wepc(wepc), .wecsb(wecsb), .wemempage(wemempage)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int kind;
        int chan;
        int data;
    } ent_t;

    ent_t q[$];
    int   starve;
    int   e_tid, e_chan, e_d8, e_d12, e_psel, e_dpc;
    int   e_wea, e_web, e_wep, e_wepc, e_wecsb, e_wemp, e_cready, e_pstall;
    int   n_asserts = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        check({step, ":wea"},       int'(wea),       e_wea);
        check({step, ":web"},       int'(web),       e_web);
        check({step, ":wep"},       int'(wep),       e_wep);
        check({step, ":wepc"},      int'(wepc),      e_wepc);
        check({step, ":wecsb"},     int'(wecsb),     e_wecsb);
        check({step, ":wemempage"}, int'(wemempage), e_wemp);
        check({step, ":d8"},        int'(d8),        e_d8);
        check({step, ":d12"},       int'(d12),       e_d12);
        check({step, ":dpc"},       int'(dpc),       e_dpc);
        check({step, ":wthreadid"}, int'(wthreadid), e_tid);
        check({step, ":wchanid"},   int'(wchanid),   e_chan);
        check({step, ":pselw"},     int'(pselw),     e_psel);
        check({step, ":cready"},    int'(cready),    e_cready);
        check({step, ":pstall"},    int'(pstall),    e_pstall);
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        e_tid = 0; e_chan = 0; e_d8 = 0; e_d12 = 0; e_psel = 0; e_dpc = 0;
        e_wea = 0; e_web = 0; e_wep = 0; e_wepc = 0; e_wecsb = 0; e_wemp = 0;
        e_cready = 0; e_pstall = 0;
    endtask

    // One clock: model the edge from the current inputs, then check outputs
    task automatic tick(input string step);
        bit   uses_bus, do_push, do_pop, was_full;
        ent_t h, n;
        uses_bus = pv && (pdst != 2'd0);
        was_full = (q.size() == FIFO_DEPTH);
        do_push  = cvalid && (e_cready != 0);
        do_pop   = (q.size() != 0) && !uses_bus;
        n.kind = int'(ckind); n.chan = int'(cchanid); n.data = int'(cdata);
        @(posedge clk);
        e_wea = 0; e_web = 0; e_wep = 0; e_wepc = 0; e_wecsb = 0; e_wemp = 0;
        if (pv) begin
            if (pdst == 2'd1) begin e_wea = 1; e_d8 = int'(pd8); e_tid = int'(pthreadid); end
            if (pdst == 2'd2) begin e_web = 1; e_d8 = int'(pd8); e_tid = int'(pthreadid); end
            if (pdst == 2'd3) begin
                e_wep = 1; e_psel = int'(ppsel); e_d12 = int'(pd12);
                e_tid = int'(pthreadid); e_chan = int'(pchanid);
            end
            if (ppcen) begin e_wepc = 1; e_dpc = int'(pdpc); end
        end
        if (do_pop) begin
            h = q.pop_front();
            e_wecsb = (h.kind == 0) ? 1 : 0;
            e_wemp  = (h.kind == 1) ? 1 : 0;
            e_d8    = h.data;
            e_chan  = h.chan;
        end
        e_pstall = 0;
        if (do_pop) begin
            starve = 0;
        end else if (was_full && uses_bus) begin
            starve++;
            if (starve == STARVE_LIMIT) begin
                e_pstall = 1;
                starve = 0;
            end
        end
        if (do_push) q.push_back(n);
        e_cready = (q.size() < FIFO_DEPTH) ? 1 : 0;
        #1;
        check_all(step);
    endtask

    task automatic idle_inputs();
        pv = 1'b0; pdst = 2'd0; ppcen = 1'b0; cvalid = 1'b0;
    endtask

    initial begin
        int sent;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_reset");

        // Pipeline write to A
        pv = 1'b1; pdst = 2'd1; pthreadid = 5'h1F; pd8 = 8'hA5;
        tick("wr_a");

        // Pointer write plus PC write in the same cycle
        pdst = 2'd3; ppsel = 2'd2; pchanid = 4'h7; pd12 = 12'hABC;
        ppcen = 1'b1; pdpc = 12'h123; pthreadid = 5'h05;
        tick("wr_ptr_pc");

        // Idle holds data, clears enables
        idle_inputs();
        tick("idle_hold");

        // csb push with pipeline idle
        cvalid = 1'b1; ckind = 1'b0; cchanid = 4'h3; cdata = 8'h40;
        tick("csb_push");
        cvalid = 1'b0;
        tick("csb_issue");

        // mempage queued behind B write, then issued alongside a PC-only write
        pv = 1'b1; pdst = 2'd2; pd8 = 8'h11; pthreadid = 5'h09;
        cvalid = 1'b1; ckind = 1'b1; cchanid = 4'hC; cdata = 8'h5E;
        tick("mp_push_blocked");
        cvalid = 1'b0; pdst = 2'd0; ppcen = 1'b1; pdpc = 12'h3F0;
        tick("mp_with_pc");
        idle_inputs();
        tick("mp_idle");

        // Five pushes under continuous A traffic, honouring pstall
        sent = 0;
        for (int i = 0; i < 26; i++) begin
            pv = (e_pstall == 0);
            pdst = 2'd1; pd8 = 8'($urandom); pthreadid = 5'($urandom);
            ppcen = 1'b0;
            cvalid = (sent < 5);
            ckind = 1'(sent); cchanid = 4'(sent + 1); cdata = 8'(8'h80 + sent);
            if (cvalid && e_cready != 0) sent++;
            tick("starve");
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick("starve_drain");

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            pv = 1'b1; pdst = 2'd1; pd8 = 8'(i);
            cvalid = 1'b1; ckind = 1'(i); cchanid = 4'(9 + i); cdata = 8'(8'hC0 + i);
            tick("rst_fill");
        end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick("rst_after");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (e_pstall != 0) pv = ($urandom_range(0, 9) == 0);
            else               pv = ($urandom_range(0, 9) < 7);
            pdst = 2'($urandom); ppsel = 2'($urandom);
            pthreadid = 5'($urandom); pchanid = 4'($urandom);
            pd8 = 8'($urandom); pd12 = 12'($urandom);
            ppcen = 1'($urandom); pdpc = 12'($urandom);
            cvalid = ($urandom_range(0, 3) != 0);
            ckind = 1'($urandom); cchanid = 4'($urandom); cdata = 8'($urandom);
            tick("random");
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
